// File: rtl/seq_divider.sv
// Multi-cycle restoring (shift-subtract) divider for RISC-V DIV/DIVU/REM/REMU with a start/busy/done handshake.
// Optional macro SEQ_DIVIDER_FASTPATH_EN: divide-by-zero and signed overflow finish one cycle after start.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SEQ_DIVIDER_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? negate(v) : v;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH-1:0] dvs_mag;
    logic             quo_neg;
    logic             rem_neg;
    logic             div_zero;
    logic             ovf;

    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic             zero_in;
    logic             ovf_in;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    always_comb begin
        dvd_mag_in = magnitude(dividend, is_signed);
        dvs_mag_in = magnitude(divisor, is_signed);
        zero_in    = (divisor == '0);
        ovf_in     = is_signed && (dividend == MOST_NEG) && (divisor == '1);

        // Partial remainder stays below the divisor, so the top bit of the trial is a clean borrow flag.
        shifted = {part_rem, quo_shift[WIDTH-1]};
        trial   = shifted - {2'b00, dvs_mag};

        q_final = apply_sign(quo_shift, quo_neg);
        r_final = apply_sign(part_rem[WIDTH-1:0], rem_neg);
        if (div_zero) begin
            q_final = '1;
        end else if (ovf) begin
            q_final = MOST_NEG;
            r_final = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            count     <= '0;
            part_rem  <= '0;
            quo_shift <= '0;
            dvs_mag   <= '0;
            quo_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (FAST && (zero_in || ovf_in)) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= zero_in ? '1 : MOST_NEG;
                            remainder <= zero_in ? dividend : '0;
                        end else begin
                            state     <= CALC;
                            busy      <= 1'b1;
                            count     <= '0;
                            part_rem  <= '0;
                            quo_shift <= dvd_mag_in;
                            dvs_mag   <= dvs_mag_in;
                            quo_neg   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            rem_neg   <= is_signed & dividend[WIDTH-1];
                            div_zero  <= zero_in;
                            ovf       <= ovf_in;
                        end
                    end
                end
                CALC: begin
                    if (count == CNT_W'(WIDTH)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_final;
                        remainder <= r_final;
                    end else begin
                        count <= count + CNT_W'(1);
                        if (!trial[WIDTH+1]) begin
                            part_rem  <= trial[WIDTH:0];
                            quo_shift <= {quo_shift[WIDTH-2:0], 1'b1};
                        end else begin
                            part_rem  <= shifted[WIDTH:0];
                            quo_shift <= {quo_shift[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed RISC-V corner cases plus randomized divisions against an arithmetic model.
module tb_seq_divider;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;
`ifdef SEQ_DIVIDER_FASTPATH_EN
    localparam int SPECIAL_LAT  = 0;
    localparam int SPECIAL_BUSY = 0;
`else
    localparam int SPECIAL_LAT  = W + 1;
    localparam int SPECIAL_BUSY = W + 1;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V division rules written directly as integer arithmetic.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == MIN && b == 32'hFFFF_FFFF) begin
            q = MIN;
            r = 32'd0;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic bit is_special(input logic s, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (s && a == MIN && b == 32'hFFFF_FFFF);
    endfunction

    // Presents one request from the current (off-edge) time, then follows the handshake to done.
    // lat counts active edges after the accepting edge until done is seen; -1 means it never came.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int inject,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int bc, output int un);
        logic [31:0] q0;
        logic [31:0] r0;
        q0 = quotient;
        r0 = remainder;
        start = 1'b1;
        is_signed = s;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        is_signed = 1'($urandom);
        lat = -1;
        bc = 0;
        un = 0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bc++;
            if (quotient !== q0 || remainder !== r0) un++;
            if (k == inject) begin
                start = 1'b1;
                dividend = 32'd7;
                divisor = 32'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        q = quotient;
        r = remainder;
    endtask

    logic [31:0] q, r, eq, er, a, b;
    logic        s;
    int          lat, bc, un, mode;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, -1, q, r, lat, bc, un);
        check("u100_7_q", q, 32'd14);
        check("u100_7_r", r, 32'd2);
        check("u100_7_lat", lat, W + 1);
        check("u100_7_busy", bc, W + 1);

        @(negedge clk);
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, -1, q, r, lat, bc, un);
        check("sm100_7_q", q, 32'hFFFF_FFF2);
        check("sm100_7_r", r, 32'hFFFF_FFFE);

        @(negedge clk);
        do_div(1'b1, 32'd100, 32'hFFFF_FFF9, -1, q, r, lat, bc, un);
        check("s100_m7_q", q, 32'hFFFF_FFF2);
        check("s100_m7_r", r, 32'd2);

        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            do_div(1'(m), 32'h1234_5678, 32'd0, -1, q, r, lat, bc, un);
            check("div0_q", q, 32'hFFFF_FFFF);
            check("div0_r", r, 32'h1234_5678);
            check("div0_lat", lat, SPECIAL_LAT);
            check("div0_busy", bc, SPECIAL_BUSY);
        end
        @(negedge clk);
        do_div(1'b1, 32'h8765_4321, 32'd0, -1, q, r, lat, bc, un);
        check("div0_neg_q", q, 32'hFFFF_FFFF);
        check("div0_neg_r", r, 32'h8765_4321);

        @(negedge clk);
        do_div(1'b1, MIN, 32'hFFFF_FFFF, -1, q, r, lat, bc, un);
        check("ovf_s_q", q, MIN);
        check("ovf_s_r", r, 32'd0);
        check("ovf_s_lat", lat, SPECIAL_LAT);
        @(negedge clk);
        do_div(1'b0, MIN, 32'hFFFF_FFFF, -1, q, r, lat, bc, un);
        check("ovf_u_q", q, 32'd0);
        check("ovf_u_r", r, MIN);
        check("ovf_u_lat", lat, W + 1);

        @(negedge clk);
        do_div(1'b0, 32'd1000, 32'd3, 5, q, r, lat, bc, un);
        check("ignore_q", q, 32'd333);
        check("ignore_r", r, 32'd1);
        check("ignore_lat", lat, W + 1);
        check("ignore_stable", un, 0);

        @(negedge clk);
        do_div(1'b0, 32'd50000, 32'd123, -1, q, r, lat, bc, un);
        check("b2b_first_q", q, 32'd406);
        check("b2b_first_r", r, 32'd62);
        do_div(1'b1, 32'hFFFF_3CB0, 32'd123, -1, q, r, lat, bc, un);
        check("b2b_second_q", q, 32'hFFFF_FE6A);
        check("b2b_second_r", r, 32'hFFFF_FFC2);
        check("b2b_second_lat", lat, W + 1);
        check("b2b_no_idle_busy", bc, W + 1);
        check("b2b_hold_prev", un, 0);

        repeat (5) @(posedge clk);
        #1;
        check("idle_hold_q", quotient, 32'hFFFF_FE6A);
        check("idle_hold_r", remainder, 32'hFFFF_FFC2);
        check("idle_done_low", 32'(done), 32'd0);

        @(negedge clk);
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd12345;
        divisor = 32'd67;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, -1, q, r, lat, bc, un);
        check("post_reset_q", q, 32'h0FFF_FFFF);
        check("post_reset_r", r, 32'hF);
        check("post_reset_lat", lat, W + 1);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            if (mode == 0) begin
                b = 32'd0;
            end else if (mode == 1) begin
                s = 1'b1;
                a = MIN;
                b = 32'hFFFF_FFFF;
            end else if (mode < 5) begin
                b = $urandom_range(1, 255);
                if (s && $urandom_range(0, 1) == 1) b = -b;
            end
            model(s, a, b, eq, er);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            do_div(s, a, b, -1, q, r, lat, bc, un);
            check("rand_q", q, eq);
            check("rand_r", r, er);
            check("rand_lat", lat, is_special(s, a, b) ? SPECIAL_LAT : W + 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
